// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: machine word width, the HALT
// opcode and the sequencer state encoding.
package fetch_pkg;

    localparam int XLEN = 32;

    // instr[6:0] value that marks the end of the program
    localparam logic [6:0] HALT_OPCODE = 7'h7F;

    typedef enum logic [2:0] {
        WARMUP,
        RUN,
        DRAIN,
        HALTED,
        FAULT
    } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bus between the sequencer, the instruction store and the
// decode/execute stages.
//   master : the sequencer (drives pc/next_pc and status, reads instr and
//            pipeline controls)
//   slave  : the surrounding pipeline / instruction store
interface fetch_sequencer_if
    import fetch_pkg::*;
();
    logic [XLEN-1:0] instr;        // word at pc
    logic            stall;        // load-use hold from decode
    logic            redirect;     // taken jump/branch from execute
    logic [XLEN-1:0] redirect_pc;  // word-address target
    logic            restart;      // leave HALTED/FAULT
    logic [XLEN-1:0] pc;           // current fetch word address
    logic [XLEN-1:0] next_pc;      // pc+1 for link computation
    logic            fetch_valid;  // instr is a real instruction this cycle
    logic            flush;        // squash younger instructions in IF/ID
    logic            halted;       // program completed
    logic            fault;        // pc left the legal range

    modport master (
        input  instr, stall, redirect, redirect_pc, restart,
        output pc, next_pc, fetch_valid, flush, halted, fault
    );

    modport slave (
        output instr, stall, redirect, redirect_pc, restart,
        input  pc, next_pc, fetch_valid, flush, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Candidate next-pc selection with range check.
//   pc_i          : current pc
//   redirect_i    : choose redirect_pc_i instead of pc_i+1
//   redirect_pc_i : redirect target (unsigned word address)
//   pc_o          : candidate value to load into pc
//   fault_o       : candidate is outside 0..IMEM_DEPTH-1 and must not load
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int IMEM_DEPTH = 64
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o
);
    always_comb begin
        pc_o    = redirect_i ? redirect_pc_i : (pc_i + XLEN'(1));
        // Unsigned compare: negative redirect targets land here as huge values.
        fault_o = (pc_o >= XLEN'(IMEM_DEPTH));
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter and decides each cycle whether it
// advances, holds, redirects or stops. Handles startup warm-up, stall hold,
// redirect with flush, HALT drain and the out-of-range fault.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   fs_if : fetch bus (master side), see fetch_sequencer_if
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int IMEM_DEPTH     = 64,
    parameter int STARTUP_CYCLES = 2,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   fs_if
);
    localparam int CNT_MAX = (STARTUP_CYCLES > DRAIN_CYCLES) ? STARTUP_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc_q;
    logic            flush_q;
    logic            halted_q;
    logic            fault_q;

    logic [XLEN-1:0] pc_d;
    logic            pc_fault_d;
    logic            is_halt;
    logic            advance;

    pc_next_sel #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_pc_next_sel (
        .pc_i          (pc_q),
        .redirect_i    (fs_if.redirect),
        .redirect_pc_i (fs_if.redirect_pc),
        .pc_o          (pc_d),
        .fault_o       (pc_fault_d)
    );

    always_comb begin
        is_halt = (fs_if.instr[6:0] == HALT_OPCODE);
        // pc moves on a redirect (RUN or DRAIN) or a plain sequential step in RUN.
        advance = fs_if.redirect ||
                  ((state_q == RUN) && !fs_if.stall && !is_halt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WARMUP;
            cnt_q     <= '0;
            pc_q      <= '0;
            next_pc_q <= XLEN'(1);
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                WARMUP: begin
                    if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN, DRAIN: begin
                    if (advance) begin
                        if (pc_fault_d) begin
                            // Illegal target: keep the old pc and stop.
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            pc_q      <= pc_d;
                            next_pc_q <= pc_d + XLEN'(1);
                            flush_q   <= fs_if.redirect;
                            state_q   <= RUN;
                            cnt_q     <= '0;
                        end
                    end else if (state_q == RUN) begin
                        // Not advancing in RUN: either stalled (hold) or HALT seen.
                        if (!fs_if.stall) begin
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HALTED, FAULT: begin
                    if (fs_if.restart) begin
                        state_q   <= WARMUP;
                        cnt_q     <= '0;
                        pc_q      <= '0;
                        next_pc_q <= XLEN'(1);
                        halted_q  <= 1'b0;
                        fault_q   <= 1'b0;
                    end
                end
                default: state_q <= WARMUP;
            endcase
        end
    end

    assign fs_if.pc          = pc_q;
    assign fs_if.next_pc     = next_pc_q;
    assign fs_if.flush       = flush_q;
    assign fs_if.halted      = halted_q;
    assign fs_if.fault       = fault_q;
    assign fs_if.fetch_valid = (state_q == RUN) && !fs_if.stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    localparam int DEPTH = 64;
    localparam int START = 2;
    localparam int DRAIN = 4;

    localparam int M_WARM  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .IMEM_DEPTH(DEPTH),
        .STARTUP_CYCLES(START),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fs_if (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [DEPTH];

    // Reference model: mode plus a countdown of cycles left in warm-up/drain.
    int     m_mode;
    int     m_left;
    longint m_pc;
    bit     m_flush;

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'h7F) w[6:0] = 7'h13;
        return w;
    endfunction

    function automatic logic [31:0] halt_instr();
        logic [31:0] w;
        w = $urandom;
        w[6:0] = 7'h7F;
        return w;
    endfunction

    task automatic fill_rom(input int halt_rate);
        for (int i = 0; i < DEPTH; i++) begin
            if (halt_rate > 0 && $urandom_range(halt_rate - 1) == 0) rom[i] = halt_instr();
            else rom[i] = rand_instr();
        end
    endtask

    function automatic void model_reset();
        m_mode  = M_WARM;
        m_left  = START;
        m_pc    = 0;
        m_flush = 0;
    endfunction

    function automatic void model_edge();
        longint tgt;
        m_flush = 0;
        case (m_mode)
            M_WARM: begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
            M_RUN, M_DRAIN: begin
                if (bus.redirect) begin
                    tgt = {32'd0, bus.redirect_pc};
                    if (tgt >= DEPTH) m_mode = M_FAULT;
                    else begin
                        m_pc = tgt;
                        m_flush = 1;
                        m_mode = M_RUN;
                    end
                end else if (m_mode == M_RUN) begin
                    if (bus.stall) begin
                        m_mode = M_RUN;
                    end else if (bus.instr[6:0] == 7'h7F) begin
                        m_mode = M_DRAIN;
                        m_left = DRAIN;
                    end else if (m_pc + 1 >= DEPTH) begin
                        m_mode = M_FAULT;
                    end else begin
                        m_pc = m_pc + 1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
            end
            default: begin
                if (bus.restart) model_reset();
            end
        endcase
    endfunction

    function automatic logic [67:0] exp_vec();
        logic [31:0] p;
        p = m_pc[31:0];
        return {p, p + 32'd1, (m_mode == M_RUN) && !bus.stall, m_flush,
                m_mode == M_HALT, m_mode == M_FAULT};
    endfunction

    function automatic logic [67:0] obs_vec();
        return {bus.pc, bus.next_pc, bus.fetch_valid, bus.flush, bus.halted, bus.fault};
    endfunction

    function automatic string fmt(input logic [67:0] v);
        return $sformatf("pc=%0d next_pc=%0d fv=%0b flush=%0b halted=%0b fault=%0b",
                         v[67:36], v[35:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic clear_inputs();
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.restart     = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        bus.instr = rom[int'(m_pc)];
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        bus.instr = rom[0];
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_rom(0);
        bus.instr = rom[0];
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd7;
        bus.restart = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== {32'd0, 32'd1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_async: got %s want pc=0 next_pc=1 fv=0 flush=0 halted=0 fault=0", fmt(obs_vec()));
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold: got %s want %s", fmt(obs_vec()), fmt(exp_vec()));
        end
        rst_n = 1'b1;
        // Junk inputs during warm-up must be ignored.
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd0) begin
            errors++;
            $display("FAIL warmup_ignore: got %s want %s", fmt(obs_vec()), fmt(exp_vec()));
        end
        clear_inputs();
    endtask

    task automatic test_sequential();
        fill_rom(0);
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL seq[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
            checks++;
            if (bus.fetch_valid !== (k >= 2) || (k >= 2 && bus.pc !== 32'(k - 2))) begin
                errors++;
                $display("FAIL seq_plan[%0d]: got pc=%0d fv=%0b want pc=%0d fv=%0b",
                         k, bus.pc, bus.fetch_valid, (k >= 2) ? k - 2 : 0, k >= 2);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 10 && m_pc != 5; k++) cycle();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.pc !== 32'd5 || bus.fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        bus.stall = 1'b0;
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd6) begin
            errors++;
            $display("FAIL stall_release: got %s want pc=6", fmt(obs_vec()));
        end
    endtask

    task automatic test_redirect_stall();
        for (int k = 0; k < 10 && m_pc != 8; k++) cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd12;
        bus.stall = 1'b1;
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd12 || bus.next_pc !== 32'd13 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL redirect_stall: got %s want pc=12 next_pc=13 flush=1", fmt(obs_vec()));
        end
        clear_inputs();
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd13 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL redirect_after: got %s want pc=13 flush=0", fmt(obs_vec()));
        end
    endtask

    task automatic test_halt();
        fill_rom(0);
        rom[3] = halt_instr();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.halted !== (k >= 10)) begin
                errors++;
                $display("FAIL halt[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        for (int k = 0; k < 3; k++) begin
            bus.stall = 1'($urandom);
            bus.redirect = 1'b1;
            bus.redirect_pc = 32'($urandom_range(DEPTH - 1));
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.pc !== 32'd3 || bus.halted !== 1'b1) begin
                errors++;
                $display("FAIL halted_frozen[%0d]: got %s want pc=3 halted=1", k, fmt(obs_vec()));
            end
        end
        clear_inputs();
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL restart: got %s want pc=0 halted=0", fmt(obs_vec()));
        end
        for (int k = 1; k <= 2; k++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.fetch_valid !== (k == 2)) begin
                errors++;
                $display("FAIL restart_warm[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_drain_redirect();
        fill_rom(0);
        rom[3] = halt_instr();
        do_reset();
        for (int k = 1; k <= 7; k++) cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd9;
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd9 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL drain_redirect: got %s want pc=9 flush=1", fmt(obs_vec()));
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.halted !== 1'b0 || (k == 0 && bus.pc !== 32'd10)) begin
                errors++;
                $display("FAIL drain_resume[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] targets [2];
        targets[0] = 32'd64;
        targets[1] = 32'hFFFF_FFF0;
        fill_rom(0);
        do_reset();
        for (int t = 0; t < 2; t++) begin
            cycle();
            cycle();
            bus.redirect = 1'b1;
            bus.redirect_pc = targets[t];
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.fault !== 1'b1 || bus.pc !== 32'd0) begin
                errors++;
                $display("FAIL fault_redirect[%0d]: got %s want pc=0 fault=1", t, fmt(obs_vec()));
            end
            bus.redirect_pc = 32'd5;
            bus.stall = 1'b1;
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.pc !== 32'd0 || bus.halted !== 1'b0) begin
                errors++;
                $display("FAIL fault_frozen[%0d]: got %s want %s", t, fmt(obs_vec()), fmt(exp_vec()));
            end
            clear_inputs();
            bus.restart = 1'b1;
            cycle();
            bus.restart = 1'b0;
        end
        cycle();
        cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd63;
        cycle();
        bus.redirect = 1'b0;
        cycle();
        checks++;
        if (obs_vec() !== exp_vec() || bus.pc !== 32'd63 || bus.next_pc !== 32'd64 || bus.fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_increment: got %s want pc=63 next_pc=64 fault=1", fmt(obs_vec()));
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== {32'd0, 32'd1, 4'b0000}) begin
            errors++;
            $display("FAIL fault_async_reset: got %s want pc=0 next_pc=1 all flags 0", fmt(obs_vec()));
        end
        @(posedge clk);
        #1;
        bus.instr = rom[0];
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        fill_rom(8);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bus.stall = ($urandom_range(3) == 0);
            bus.redirect = ($urandom_range(5) == 0);
            bus.redirect_pc = ($urandom_range(9) == 0) ? 32'($urandom) : 32'($urandom_range(DEPTH - 1));
            bus.restart = ($urandom_range(9) == 0);
            cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        bus.instr = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_drain_redirect();
        test_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
